// File: rtl/cache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill_ctrl_if
// Purpose  : Bundles the cache-side request/ack signals and the memory-side
//            miss/fill signals of the refill controller.
// Ports    : ic_req/ic_addr/ic_ack/ic_line  - icache refill channel
//            dc_req/dc_addr/dc_ack/dc_line  - dcache refill channel
//            imiss/iaddr, dmiss/daddr       - miss requests toward memory
//            data, ifill, dfill             - beats returned by memory
//            busy, err                      - controller status
// Modports : master - the refill controller
//            slave  - the caches and memory around it
// Revision : 1.0 - initial release
// ============================================================================
interface cache_refill_ctrl_if #(
  parameter int LINE_BEATS = 2
);
  logic                      ic_req;
  logic [31:0]               ic_addr;
  logic                      ic_ack;
  logic [64*LINE_BEATS-1:0]  ic_line;
  logic                      dc_req;
  logic [31:0]               dc_addr;
  logic                      dc_ack;
  logic [64*LINE_BEATS-1:0]  dc_line;
  logic                      imiss;
  logic [31:0]               iaddr;
  logic                      dmiss;
  logic [31:0]               daddr;
  logic [63:0]               data;
  logic                      ifill;
  logic                      dfill;
  logic                      busy;
  logic                      err;

  modport master (
    input  ic_req, ic_addr, dc_req, dc_addr, data, ifill, dfill,
    output ic_ack, ic_line, dc_ack, dc_line, imiss, iaddr, dmiss, daddr,
           busy, err
  );

  modport slave (
    output ic_req, ic_addr, dc_req, dc_addr, data, ifill, dfill,
    input  ic_ack, ic_line, dc_ack, dc_line, imiss, iaddr, dmiss, daddr,
           busy, err
  );
endinterface
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill_ctrl
// Purpose  : Arbitrates icache/dcache line refills (dcache has priority),
//            fetches the line from memory one 64-bit beat at a time with a
//            one-cycle miss gap between beats, assembles the beats and
//            returns the line with a one-cycle ack. A watchdog aborts a
//            refill whose beat never arrives and flags it with err.
// Ports    : clk   - rising-edge clock
//            reset - asynchronous, active-high reset
//            bus   - cache_refill_ctrl_if.master (cache and memory signals)
// Params   : LINE_BEATS - beats per line, power of two, >= 1
//            TIMEOUT    - cycles waited for a beat before aborting, >= 4
// Revision : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl #(
  parameter int LINE_BEATS = 2,
  parameter int TIMEOUT    = 64
) (
  input  wire logic            clk,
  input  wire logic            reset,
  cache_refill_ctrl_if.master  bus
);

  localparam int c_BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int c_WD_W   = $clog2(TIMEOUT);
  localparam int c_LINE_W = 64 * LINE_BEATS;

  // Byte-offset bits inside one line; cleared to form the line base.
  localparam logic [31:0]         c_OFF_MASK  = 32'(8 * LINE_BEATS - 1);
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(LINE_BEATS - 1);
  localparam logic [c_WD_W-1:0]   c_WD_LAST   = c_WD_W'(TIMEOUT - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_GAP  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic                 r_sel_d;       // 1: dcache refill, 0: icache refill
  logic [31:0]          r_base;
  logic [c_BEAT_W-1:0]  r_beat;
  logic [c_WD_W-1:0]    r_wdog;
  logic                 r_abort;
  logic [c_LINE_W-1:0]  r_ic_line;
  logic [c_LINE_W-1:0]  r_dc_line;
  logic [c_LINE_W-1:0]  w_ic_line_nxt;
  logic [c_LINE_W-1:0]  w_dc_line_nxt;

  logic                  w_accept;
  logic                  w_fill;
  logic                  w_capture;
  logic                  w_last;
  logic                  w_wd_expired;
  logic [31:0]           w_req_addr;
  logic [31:0]           w_beat_addr;
  logic [LINE_BEATS-1:0] w_slot_hit;

  assign w_accept     = (r_state == c_IDLE) && (bus.dc_req || bus.ic_req);
  assign w_req_addr   = bus.dc_req ? bus.dc_addr : bus.ic_addr;
  // Only the selected channel's fill counts; the other one is ignored.
  assign w_fill       = r_sel_d ? bus.dfill : bus.ifill;
  assign w_capture    = (r_state == c_REQ) && w_fill;
  assign w_last       = (r_beat == c_LAST_BEAT);
  assign w_wd_expired = (r_wdog == c_WD_LAST);
  assign w_beat_addr  = r_base + (32'(r_beat) << 3);

  // One-hot decode of the beat counter onto the line slots.
  for (genvar k = 0; k < LINE_BEATS; k++) begin : g_slot
    localparam logic [c_BEAT_W-1:0] c_K = c_BEAT_W'(k);
    assign w_slot_hit[k] = (r_beat == c_K);
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. A fill on the last beat wins over a watchdog
  // expiry in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_next_state = c_REQ;
        end
      end
      c_REQ: begin
        if (w_fill) begin
          w_next_state = w_last ? c_DONE : c_GAP;
        end else if (w_wd_expired) begin
          w_next_state = c_DONE;
        end
      end
      c_GAP:   w_next_state = c_REQ;
      c_DONE:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Everything but the line buffers is decoded from state, so
  // an asynchronous reset drops all outputs at once.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.imiss  = 1'b0;
    bus.iaddr  = '0;
    bus.dmiss  = 1'b0;
    bus.daddr  = '0;
    bus.ic_ack = 1'b0;
    bus.dc_ack = 1'b0;
    bus.err    = 1'b0;
    bus.busy   = (r_state != c_IDLE);
    case (r_state)
      c_REQ: begin
        if (r_sel_d) begin
          bus.dmiss = 1'b1;
          bus.daddr = w_beat_addr;
        end else begin
          bus.imiss = 1'b1;
          bus.iaddr = w_beat_addr;
        end
      end
      c_DONE: begin
        if (r_sel_d) begin
          bus.dc_ack = 1'b1;
        end else begin
          bus.ic_ack = 1'b1;
        end
        bus.err = r_abort;
      end
      default: ;
    endcase
  end

  assign bus.ic_line = r_ic_line;
  assign bus.dc_line = r_dc_line;

  // --------------------------------------------------------------------------
  // Line buffers: each port's line is cleared when that port is accepted,
  // filled beat by beat, and otherwise held so it stays readable after ack.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ic_line_nxt = r_ic_line;
    w_dc_line_nxt = r_dc_line;
    if (w_accept) begin
      if (bus.dc_req) begin
        w_dc_line_nxt = '0;
      end else begin
        w_ic_line_nxt = '0;
      end
    end
    for (int k = 0; k < LINE_BEATS; k++) begin
      if (w_capture && w_slot_hit[k]) begin
        if (r_sel_d) begin
          w_dc_line_nxt[64*k +: 64] = bus.data;
        end else begin
          w_ic_line_nxt[64*k +: 64] = bus.data;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Refill datapath: selection, base address, beat counter, watchdog.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_d   <= 1'b0;
      r_base    <= '0;
      r_beat    <= '0;
      r_wdog    <= '0;
      r_abort   <= 1'b0;
      r_ic_line <= '0;
      r_dc_line <= '0;
    end else begin
      r_ic_line <= w_ic_line_nxt;
      r_dc_line <= w_dc_line_nxt;
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_sel_d <= bus.dc_req;
            r_base  <= w_req_addr & ~c_OFF_MASK;
            r_beat  <= '0;
            r_wdog  <= '0;
            r_abort <= 1'b0;
          end
        end
        c_REQ: begin
          if (w_fill) begin
            r_wdog <= '0;
            if (!w_last) begin
              r_beat <= r_beat + c_BEAT_W'(1);
            end
          end else if (w_wd_expired) begin
            r_abort <= 1'b1;
          end else begin
            r_wdog <= r_wdog + c_WD_W'(1);
          end
        end
        c_DONE: begin
          r_abort <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_refill_ctrl
// Purpose  : Directed bench for cache_refill_ctrl. A memory responder answers
//            each miss on its 4th cycle; a cycle model predicts every output
//            and a table of hand-computed refill results pins each ack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_refill_ctrl;

  localparam int LINE_BEATS = 2;
  localparam int TIMEOUT    = 16;
  localparam int LW         = 64 * LINE_BEATS;
  localparam logic [31:0] OFF_MASK = 32'(8 * LINE_BEATS - 1);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cache_refill_ctrl_if #(.LINE_BEATS(LINE_BEATS)) bus ();

  cache_refill_ctrl #(
    .LINE_BEATS (LINE_BEATS),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Controls and expected-ack table, written only by the stimulus process.
  bit            mem_on   = 1'b1;
  bit            stray_on = 1'b0;
  bit            done     = 1'b0;
  int            n_exp    = 0;
  bit            exp_port [16];   // 1: dcache, 0: icache
  logic [31:0]   exp_addr [16];   // first beat address of the refill
  logic [LW-1:0] exp_line [16];
  bit            exp_err  [16];

  int vectors    = 0;
  int miscompares = 0;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 64'hAAAA_AAAA_AAAA_AAAA;
      32'h108: return 64'hBBBB_BBBB_BBBB_BBBB;
      default: return {~a, a ^ 32'h1234_5678};
    endcase
  endfunction

  function automatic logic [LW-1:0] line_of(input logic [31:0] a);
    logic [LW-1:0] l;
    logic [31:0]   base;
    base = a & ~OFF_MASK;
    for (int k = 0; k < LINE_BEATS; k++) l[64*k +: 64] = mem_word(base + 32'(8 * k));
    return l;
  endfunction

  // --------------------------------------------------------------------------
  // Memory responder: a miss held for 4 cycles gets its fill in the 4th.
  // --------------------------------------------------------------------------
  initial begin : memory
    int icnt, dcnt, tick;
    icnt = 0; dcnt = 0; tick = 0;
    bus.ifill = 1'b0;
    bus.dfill = 1'b0;
    bus.data  = '0;
    forever begin
      @(posedge clk); #1;
      tick++;
      bus.ifill = 1'b0;
      bus.dfill = 1'b0;
      bus.data  = 64'hDEAD_BEEF_0BAD_F00D;
      icnt = bus.imiss ? icnt + 1 : 0;
      dcnt = bus.dmiss ? dcnt + 1 : 0;
      if (mem_on && icnt == 4) begin bus.ifill = 1'b1; bus.data = mem_word(bus.iaddr); end
      if (mem_on && dcnt == 4) begin bus.dfill = 1'b1; bus.data = mem_word(bus.daddr); end
      if (stray_on && (tick % 2 == 1)) bus.ifill = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Compare process with the cycle model of the controller.
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  initial begin : compare
    bit            m_active, m_gap, m_ack, m_abort, m_sel_d, m_first_pend;
    logic [31:0]   m_base, m_first_addr;
    int            m_beats, m_run, rd, cyc;
    logic [LW-1:0] m_ic_line, m_dc_line;
    logic          exp_i, exp_d;
    m_active = 0; m_gap = 0; m_ack = 0; m_abort = 0; m_sel_d = 0; m_first_pend = 0;
    m_base = '0; m_first_addr = '0; m_beats = 0; m_run = 0; rd = 0; cyc = 0;
    m_ic_line = '0; m_dc_line = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done || cyc > 5000) begin
        if (!done) begin
          miscompares++;
          $display("FAIL run_budget: %0d cycles elapsed, expected stimulus to finish sooner", cyc);
        end
        chk("acks_seen", LW'(rd), LW'(n_exp));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
      if (reset) begin
        chk("reset_ctrl", LW'({bus.imiss, bus.iaddr, bus.dmiss, bus.daddr,
                               bus.ic_ack, bus.dc_ack, bus.busy, bus.err}), '0);
        chk("reset_ic_line", bus.ic_line, '0);
        chk("reset_dc_line", bus.dc_line, '0);
        m_active = 0; m_gap = 0; m_ack = 0; m_abort = 0; m_first_pend = 0;
        m_ic_line = '0; m_dc_line = '0;
        continue;
      end

      exp_i = m_active && !m_gap && !m_ack && !m_sel_d;
      exp_d = m_active && !m_gap && !m_ack &&  m_sel_d;
      chk("imiss", LW'(bus.imiss), LW'(exp_i));
      chk("dmiss", LW'(bus.dmiss), LW'(exp_d));
      chk("iaddr", LW'(bus.iaddr), exp_i ? LW'(m_base + 32'(8 * m_beats)) : '0);
      chk("daddr", LW'(bus.daddr), exp_d ? LW'(m_base + 32'(8 * m_beats)) : '0);
      chk("busy",  LW'(bus.busy),  LW'(m_active));
      chk("ic_ack", LW'(bus.ic_ack), LW'(m_ack && !m_sel_d));
      chk("dc_ack", LW'(bus.dc_ack), LW'(m_ack &&  m_sel_d));
      chk("err",   LW'(bus.err),   LW'(m_ack && m_abort));
      if (!m_active || m_sel_d || m_ack) chk("ic_line", bus.ic_line, m_ic_line);
      if (!m_active || !m_sel_d || m_ack) chk("dc_line", bus.dc_line, m_dc_line);

      if (m_first_pend && (exp_i || exp_d)) begin
        m_first_addr = m_sel_d ? bus.daddr : bus.iaddr;
        m_first_pend = 0;
      end

      if (m_ack) begin
        if (rd < n_exp) begin
          chk("tbl_port", LW'({bus.dc_ack, bus.ic_ack}), LW'({exp_port[rd], !exp_port[rd]}));
          chk("tbl_addr", LW'(m_first_addr), LW'(exp_addr[rd]));
          chk("tbl_line", exp_port[rd] ? bus.dc_line : bus.ic_line, exp_line[rd]);
          chk("tbl_err",  LW'(bus.err), LW'(exp_err[rd]));
        end else begin
          miscompares++;
          $display("FAIL tbl_extra: ack number %0d seen, only %0d expected", rd + 1, n_exp);
        end
        rd++;
        m_active = 0; m_ack = 0; m_abort = 0;
      end else if (m_gap) begin
        m_gap = 0;
      end else if (m_active) begin
        if (m_sel_d ? bus.dfill : bus.ifill) begin
          if (m_sel_d) m_dc_line[64*m_beats +: 64] = bus.data;
          else         m_ic_line[64*m_beats +: 64] = bus.data;
          m_run = 0;
          if (m_beats == LINE_BEATS - 1) m_ack = 1;
          else begin m_beats++; m_gap = 1; end
        end else begin
          m_run++;
          if (m_run == TIMEOUT) begin m_ack = 1; m_abort = 1; end
        end
      end else if (bus.dc_req || bus.ic_req) begin
        m_active = 1; m_sel_d = bus.dc_req; m_beats = 0; m_run = 0; m_first_pend = 1;
        m_base = (bus.dc_req ? bus.dc_addr : bus.ic_addr) & ~OFF_MASK;
        if (bus.dc_req) m_dc_line = '0; else m_ic_line = '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic expect_ack(input bit dport, input logic [31:0] a,
                            input logic [LW-1:0] l, input bit e);
    exp_port[n_exp] = dport;
    exp_addr[n_exp] = a;
    exp_line[n_exp] = l;
    exp_err[n_exp]  = e;
    n_exp++;
  endtask

  task automatic wait_ack(input bit dport);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (dport ? bus.dc_ack : bus.ic_ack) break;
    end
  endtask

  task automatic refill(input bit dport, input logic [31:0] a);
    @(posedge clk); #2;
    if (dport) begin bus.dc_addr = a; bus.dc_req = 1'b1; end
    else       begin bus.ic_addr = a; bus.ic_req = 1'b1; end
    wait_ack(dport);
    if (dport) bus.dc_req = 1'b0; else bus.ic_req = 1'b0;
  endtask

  initial begin : stim
    bus.ic_req = 1'b0; bus.ic_addr = '0;
    bus.dc_req = 1'b0; bus.dc_addr = '0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);

    // Basic icache refill from an unaligned address.
    expect_ack(1'b0, 32'h100, {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 1'b0);
    refill(1'b0, 32'h104);

    // Simultaneous requests: dcache first, then icache.
    expect_ack(1'b1, 32'h200, {64'hFFFF_FDF7_1234_5470, 64'hFFFF_FDFF_1234_5478}, 1'b0);
    expect_ack(1'b0, 32'h300, {64'hFFFF_FCF7_1234_5570, 64'hFFFF_FCFF_1234_5578}, 1'b0);
    @(posedge clk); #2;
    bus.dc_addr = 32'h200; bus.ic_addr = 32'h300;
    bus.dc_req = 1'b1; bus.ic_req = 1'b1;
    wait_ack(1'b1); bus.dc_req = 1'b0;
    wait_ack(1'b0); bus.ic_req = 1'b0;

    // Stray instruction-side fills during a dcache refill.
    expect_ack(1'b1, 32'h700, line_of(32'h70C), 1'b0);
    stray_on = 1'b1;
    refill(1'b1, 32'h70C);
    stray_on = 1'b0;

    // Memory never answers: watchdog abort.
    expect_ack(1'b1, 32'h600, '0, 1'b1);
    mem_on = 1'b0;
    refill(1'b1, 32'h600);
    mem_on = 1'b1;

    // Reset during the gap of a refill, then a clean refill.
    @(posedge clk); #2;
    bus.ic_addr = 32'h400; bus.ic_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (bus.imiss && bus.ifill) break;
    end
    @(posedge clk); #2;
    reset = 1'b1; bus.ic_req = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    expect_ack(1'b0, 32'h500, {64'hFFFF_FAF7_1234_5370, 64'hFFFF_FAFF_1234_5378}, 1'b0);
    refill(1'b0, 32'h500);

    // Request dropped right after it is accepted.
    expect_ack(1'b0, 32'h800, line_of(32'h800), 1'b0);
    @(posedge clk); #2;
    bus.ic_addr = 32'h808; bus.ic_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (bus.imiss) break;
    end
    bus.ic_req = 1'b0;
    wait_ack(1'b0);

    repeat (10) @(posedge clk);
    done = 1'b1;
  end

endmodule
`default_nettype wire

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Cache-side refill controller and initiator for the `memory` block's miss/fill protocol. It accepts line-refill requests from the instruction cache and the data cache, arbitrates between them, and drives `imiss`/`dmiss` and `iaddr`/`daddr` toward memory one 64-bit beat at a time. It assembles the returned `data` beats into a full line and hands the line back to the requesting cache with a one-cycle acknowledge. A watchdog reports a memory that never answers.

## Interface
- `LINE_BEATS`, default 2: 64-bit beats per cache line. Must be a power of two, ≥1.
- `TIMEOUT`, default 64: cycles to wait for a fill before the refill is aborted. Must be ≥4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ic_req`  in  1  icache refill request; held high until `ic_ack`.
- `ic_addr`  in  32  icache miss byte address.
- `ic_ack`  out  1  one-cycle pulse; `ic_line` is valid in this cycle.
- `ic_line`  out  64*LINE_BEATS  refilled line; beat k occupies bits [64k+63:64k].
- `dc_req`, `dc_addr`, `dc_ack`, `dc_line`: same as the four icache ports above, for the dcache.
- `imiss`  out  1  instruction-side miss request to memory.
- `iaddr`  out  32  instruction-side beat address.
- `dmiss`  out  1  data-side miss request to memory.
- `daddr`  out  32  data-side beat address.
- `data`  in  64  beat returned by memory.
- `ifill`  in  1  memory has returned an instruction-side beat.
- `dfill`  in  1  memory has returned a data-side beat.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  high together with the ack pulse of a timed-out refill.

## Operation
- States: IDLE, REQ, GAP, DONE.
- Reset values (applied asynchronously): state IDLE, all outputs 0, line buffer 0, beat counter 0, watchdog 0.
- **IDLE**
  - If `dc_req` is high: dcache wins, even if `ic_req` is also high. Otherwise, if `ic_req` is high: icache wins.
  - On accept: latch `sel`, latch base = addr with bits [log2(8*LINE_BEATS)-1:0] cleared, clear the line buffer, clear the beat counter, go to REQ.
- **REQ**
  - Assert the selected miss line. Drive the selected addr = base + 8*beat. The unselected miss and addr are 0.
  - The watchdog increments every cycle.
  - Selected fill sampled high: capture `data` into the slot for the current beat, clear the watchdog.
    - If that was the last beat: go to DONE.
    - Otherwise: increment the beat counter and go to GAP.
  - Watchdog reaches TIMEOUT-1 with no fill: set the abort flag and go to DONE.
- **GAP**
  - Miss deasserted for exactly one cycle so memory re-arms, then back to REQ.
- **DONE**
  - Selected ack high for one cycle. `err` equals the abort flag.
  - Unfilled beats read 0.
  - Go to IDLE; the abort flag clears.
- Fill on the unselected channel: ignored in all states.
- Any fill while in IDLE, GAP or DONE: ignored.
- Requests are not preempted. A requester dropping `req` mid-refill does not cancel it; the refill completes and the ack still pulses.
- The losing requester is served after the current refill ends. Its address is sampled when it is accepted, not earlier.
- Address arithmetic is 32-bit; wrap past 0xFFFFFFFF is allowed and unchecked.

## Timing
- Request high at edge t (IDLE) → miss high from t+1.
- Fill sampled at edge f → data captured at f.
  - Not last beat: miss low during cycle f+1 (GAP), high again from f+2 with the next address.
  - Last beat: ack high in cycle f+1.
- With the memory block's fixed 3-cycle miss-to-fill latency: one beat takes 4 cycles in REQ plus 1 in GAP.
- Earliest re-accept: the cycle after ack (IDLE). Back-to-back requests are therefore spaced by at least one idle cycle.
- `ic_line`/`dc_line` hold their value after ack until the next accept for that port.
- Reset asserted mid-refill:
  - All outputs drop to 0 immediately; no ack is generated.
  - The first request after reset release is accepted normally.

## Test plan
- Icache refill: `ic_addr`=0x104; memory model returns 0xA…A then 0xB…B.
  - `iaddr`=0x100, then 0x108.
  - `ic_ack` one cycle with `ic_line`={0xB…B,0xA…A} and `err`=0.
- `ic_req` and `dc_req` raised in the same cycle, `dc_addr`=0x200, `ic_addr`=0x300.
  - dcache fetches 0x200/0x208 and `dc_ack` pulses first.
  - Then `imiss` fetches 0x300/0x308 and `ic_ack` pulses.
- Stray `ifill` pulses during a dcache refill → ignored; `dc_line` matches the data-side beats only, and `ic_ack` stays 0.
- Memory never fills → `dmiss` held for TIMEOUT cycles, then `dc_ack`=1 with `err`=1 and `dc_line`=0; controller returns to IDLE.
- `reset` pulsed during the GAP of a refill at 0x400 → outputs 0 at once and no ack; a new request at 0x500 refills 0x500/0x508 correctly.
- `ic_req` dropped after accept → refill still completes and `ic_ack` pulses once.
